// File: rtl/simon_key_sched_stream.sv
// simon_key_sched_stream
//   Streams SIMON round keys k[0..ROUNDS-1] from a master key, one key per
//   rk_valid/rk_ready handshake. A sliding window of KEY_WORDS words holds
//   k[i..i+m-1]. Each accepted key shifts the window and appends the next
//   derived word, so the first m outputs are the raw key words.
module simon_key_sched_stream #(
   parameter int WORD_W    = 32,
   parameter int KEY_WORDS = 4,
   parameter int ROUNDS    = 44,
   parameter int Z_SEQ     = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
   output logic                          busy,
   output logic                          rk_valid,
   input  logic                          rk_ready,
   output logic [WORD_W-1:0]             rk_data,
   output logic [$clog2(ROUNDS)-1:0]     rk_index,
   output logic                          done
);

   localparam int IDX_W = $clog2(ROUNDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   // Reject configurations the key expansion is not defined for.
   if (KEY_WORDS < 2 || KEY_WORDS > 4 || Z_SEQ < 0 || Z_SEQ > 4 || ROUNDS < KEY_WORDS) begin : g_param_err
      $error("simon_key_sched_stream: illegal KEY_WORDS/Z_SEQ/ROUNDS combination");
   end

   // The five SIMON constant sequences; z[0] is the leftmost (MSB) bit.
   function automatic logic [61:0] z_const(input int sel);
      case (sel)
         0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
         1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
         2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
         3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
         4:       return 62'b11010001111001101011011000100000010111000011001010010011101111;
         default: return 62'b0;
      endcase
   endfunction

   localparam logic [61:0] Z_BITS = z_const(Z_SEQ);

   // Rotate right by one bit within the word.
   function automatic logic [WORD_W-1:0] ror1(input logic [WORD_W-1:0] x);
      return {x[0], x[WORD_W-1:1]};
   endfunction

   // Rotate right by three bits within the word.
   function automatic logic [WORD_W-1:0] ror3(input logic [WORD_W-1:0] x);
      return {x[2:0], x[WORD_W-1:3]};
   endfunction

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t            state_r;
   logic [WORD_W-1:0] win_r [KEY_WORDS];
   logic [5:0]        zptr_r;
   logic [IDX_W-1:0]  idx_r;
   logic              busy_r;
   logic              valid_r;
   logic              done_r;

   logic              z_bit_s;
   logic [WORD_W-1:0] tmp_a_s;
   logic [WORD_W-1:0] tmp_b_s;
   logic [WORD_W-1:0] knew_s;

   // Next key word derived from the current window and z pointer.
   always_comb begin
      z_bit_s = Z_BITS[6'd61 - zptr_r];
      tmp_a_s = ror3(win_r[KEY_WORDS-1]) ^ ((KEY_WORDS == 4) ? win_r[1] : {WORD_W{1'b0}});
      tmp_b_s = tmp_a_s ^ ror1(tmp_a_s);
      knew_s  = ~win_r[0] ^ tmp_b_s ^ {{(WORD_W-1){1'b0}}, z_bit_s} ^ WORD_W'(2'd3);
   end

   // Control FSM plus key window; all outputs come straight from registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         idx_r   <= {IDX_W{1'b0}};
         zptr_r  <= 6'd0;
         for (int j = 0; j < KEY_WORDS; j++) begin
            win_r[j] <= {WORD_W{1'b0}};
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  for (int j = 0; j < KEY_WORDS; j++) begin
                     win_r[j] <= key_in[WORD_W*j +: WORD_W];
                  end
                  idx_r   <= {IDX_W{1'b0}};
                  zptr_r  <= 6'd0;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (valid_r && rk_ready) begin
                  if (idx_r == LAST_IDX) begin
                     // Final key consumed: drop valid and pulse done.
                     valid_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     for (int j = 0; j < KEY_WORDS - 1; j++) begin
                        win_r[j] <= win_r[j+1];
                     end
                     win_r[KEY_WORDS-1] <= knew_s;
                     idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                     zptr_r  <= (zptr_r == 6'd61) ? 6'd0 : zptr_r + 6'd1;
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign rk_valid = valid_r;
   assign rk_data  = win_r[0];
   assign rk_index = idx_r;
   assign done     = done_r;

endmodule

// File: tb/tb_simon_key_sched_stream.sv
// Bench for simon_key_sched_stream: SIMON64/128 stream scenarios on the
// default instance, plus SIMON32/64 and SIMON128/128 instances, all checked
// against a from-scratch key-expansion model computed from the SIMON rules.
module tb_simon_key_sched_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   string z_tab [5] = '{
      "11111010001001010110000111001101111101000100101011000011100110",
      "10001110111110010011000010110101000111011111001001100001011010",
      "10101111011100000011010010011000101000010001111110010110110011",
      "11011011101011000110010111100000010010001010011100110100001111",
      "11010001111001101011011000100000010111000011001010010011101111"};

   // SIMON64/128 instance
   logic         start0 = 1'b0, rdy0 = 1'b1, busy0, val0, done0;
   logic [127:0] key0 = 128'h1b1a1918_13121110_0b0a0908_03020100;
   logic [31:0]  data0;
   logic [5:0]   idx0;
   // SIMON32/64 instance
   logic         start1 = 1'b0, rdy1 = 1'b1, busy1, val1, done1;
   logic [63:0]  key1 = 64'd0;
   logic [15:0]  data1;
   logic [4:0]   idx1;
   // SIMON128/128 instance
   logic         start2 = 1'b0, rdy2 = 1'b1, busy2, val2, done2;
   logic [127:0] key2 = 128'd0;
   logic [63:0]  data2;
   logic [6:0]   idx2;

   logic [63:0] exp0 [44];
   logic [63:0] exp1 [32];
   logic [63:0] exp2 [68];

   simon_key_sched_stream dut0 (
      .clk(clk), .rst(rst), .start(start0), .key_in(key0), .busy(busy0),
      .rk_valid(val0), .rk_ready(rdy0), .rk_data(data0), .rk_index(idx0), .done(done0));

   simon_key_sched_stream #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(32), .Z_SEQ(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .key_in(key1), .busy(busy1),
      .rk_valid(val1), .rk_ready(rdy1), .rk_data(data1), .rk_index(idx1), .done(done1));

   simon_key_sched_stream #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(68), .Z_SEQ(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .key_in(key2), .busy(busy2),
      .rk_valid(val2), .rk_ready(rdy2), .rk_data(data2), .rk_index(idx2), .done(done2));

   function automatic logic [63:0] wmask(input int n);
      return (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
      return ((x >> r) | (x << (n - r))) & wmask(n);
   endfunction

   // Reference: expand the whole schedule up to k[idx] the textbook way.
   function automatic logic [63:0] ref_key(input int n, input int m, input int zs,
                                           input logic [255:0] key, input int idx);
      logic [63:0] k [136];
      logic [63:0] t;
      logic [63:0] zb;
      string       s;
      s = z_tab[zs];
      for (int j = 0; j < m; j++) k[j] = 64'(key >> (n * j)) & wmask(n);
      for (int i = m; i <= idx; i++) begin
         t = ror(k[i-1], 3, n);
         if (m == 4) t = t ^ k[i-3];
         t = t ^ ror(t, 1, n);
         zb = (s[(i - m) % 62] == 8'h31) ? 64'd1 : 64'd0;
         k[i] = (~k[i-m] ^ t ^ zb ^ 64'd3) & wmask(n);
      end
      return k[idx];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic load0();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   // Consume the default stream; called one cycle after load.
   task automatic stream0(input bit rnd, input int inj, input int abort_at, input bit b2b);
      int          got = 0;
      int          cyc = 0;
      bit          stalled = 1'b0;
      logic [31:0] pd;
      logic [5:0]  pi;
      while (got < 44) begin
         chk("run_valid", val0, 1);
         chk("run_busy", busy0, 1);
         chk("run_done", done0, 0);
         chk("index", idx0, got);
         chk("data", data0, exp0[got]);
         if (stalled) begin
            chk("hold_data", data0, pd);
            chk("hold_idx", idx0, pi);
         end
         if (got == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_valid", val0, 0);
            chk("abort_busy", busy0, 0);
            chk("abort_idx", idx0, 0);
            repeat (3) begin
               @(negedge clk);
               chk("abort_nodone", done0, 0);
               chk("abort_idle", val0, 0);
            end
            return;
         end
         start0 = (got == inj);
         rdy0   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         pd = data0;
         pi = idx0;
         @(negedge clk);
         start0 = 1'b0;
         if (rdy0) begin
            got++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
         end
         cyc++;
         if (cyc > 1000) begin
            chk("timeout_got", got, 44);
            return;
         end
      end
      rdy0 = 1'b1;
      chk("done_pulse", done0, 1);
      chk("end_valid", val0, 0);
      chk("end_busy", busy0, 0);
      if (b2b) begin
         start0 = 1'b1;
         @(negedge clk);
         start0 = 1'b0;
         chk("b2b_done_low", done0, 0);
         chk("b2b_valid", val0, 1);
         chk("b2b_idx", idx0, 0);
         chk("b2b_data", data0, exp0[0]);
      end else begin
         @(negedge clk);
         chk("done_once", done0, 0);
      end
   endtask

   initial begin
      int got;
      int cyc;
      for (int i = 0; i < 44; i++) exp0[i] = ref_key(32, 4, 3, {128'd0, key0}, i);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy0, 0);
      chk("rst_valid", val0, 0);
      chk("rst_done", done0, 0);
      chk("rst_idx", idx0, 0);
      chk("rst_data", data0, 0);
      chk("rst_valid2", val2, 0);

      // Known SIMON64/128 values for the first five keys.
      chk("vec_k0", exp0[0], 64'h03020100);
      chk("vec_k4", exp0[4], 64'h70a011c3);

      load0(); stream0(1'b0, -1, -1, 1'b0);   // plain stream
      load0(); stream0(1'b1, -1, -1, 1'b0);   // random backpressure
      load0(); stream0(1'b0, 10, -1, 1'b0);   // start in RUN ignored
      load0(); stream0(1'b0, -1, 20, 1'b0);   // reset mid-stream
      load0(); stream0(1'b1, -1, -1, 1'b1);   // restart in the done cycle
      stream0(1'b0, -1, -1, 1'b0);

      // SIMON32/64 with random key and random ready
      key1 = {$urandom, $urandom};
      for (int i = 0; i < 32; i++) exp1[i] = ref_key(16, 4, 0, {192'd0, key1}, i);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 32 && cyc < 400) begin
         chk("s32_idx", idx1, got);
         chk("s32_data", data1, exp1[got]);
         rdy1 = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (rdy1) got++;
         cyc++;
      end
      if (got < 32) chk("s32_timeout", got, 32);
      chk("s32_done", done1, 1);
      chk("s32_valid_end", val1, 0);

      // SIMON128/128: 68 keys, z pointer wraps
      key2 = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 68; i++) exp2[i] = ref_key(64, 2, 2, {128'd0, key2}, i);
      rdy2 = 1'b1;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 68 && cyc < 400) begin
         chk("s128_idx", idx2, got);
         chk("s128_data", data2, exp2[got]);
         rdy2 = 1'($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (rdy2) got++;
         cyc++;
      end
      if (got < 68) chk("s128_timeout", got, 68);
      chk("s128_done", done2, 1);
      chk("s128_busy_end", busy2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
